// File: rtl/conv_scheduler.sv
// Round-robin scheduler that time-shares one convolution engine between N_REQ requesters,
// remapping the engine's Y/Z addresses into the granted requester's RAM windows.
module conv_scheduler #(
  parameter int N_REQ          = 2,
  parameter int ADDR_WIDTH_Y   = 5,
  parameter int ADDR_WIDTH_Z   = 6,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ*ADDR_WIDTH_Y-1:0]   req_size_Y,
  input  logic [N_REQ*ADDR_WIDTH_Y-1:0]   req_base_Y,
  input  logic [N_REQ*ADDR_WIDTH_Z-1:0]   req_base_Z,
  output logic [N_REQ-1:0]                cmp_valid,
  output logic [N_REQ-1:0]                cmp_error,
  output logic                            busy,
  output logic [$clog2(N_REQ)-1:0]        grant_id,
  output logic                            eng_start,
  output logic [ADDR_WIDTH_Y-1:0]         eng_mem_size_Y,
  input  logic                            eng_busy,
  input  logic                            eng_done,
  input  logic [ADDR_WIDTH_Y-1:0]         eng_mem_addr_Y,
  input  logic                            eng_write_Z,
  input  logic [ADDR_WIDTH_Z-1:0]         eng_mem_addr_Z,
  output logic [ADDR_WIDTH_Y-1:0]         mem_addr_Y,
  output logic [ADDR_WIDTH_Z-1:0]         mem_addr_Z,
  output logic                            write_Z
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_RUN = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW:0]   N_REQ_W  = (GW+1)'(N_REQ);
  localparam logic [GW-1:0] LAST_REQ = GW'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, COMPLETE} state_t;

  state_t                  state;
  logic [GW-1:0]           rr_ptr;
  logic [GW-1:0]           grant_q;
  logic [ADDR_WIDTH_Y-1:0] size_q;
  logic [ADDR_WIDTH_Y-1:0] base_y_q;
  logic [ADDR_WIDTH_Z-1:0] base_z_q;
  logic [CW-1:0]           run_cnt;
  logic [N_REQ-1:0]        cmp_valid_q;
  logic [N_REQ-1:0]        cmp_error_q;
  logic                    eng_start_q;
  logic                    busy_q;

  logic                    found;
  logic [GW-1:0]           pick;
  logic [GW:0]             cand;
  logic                    accept;
  logic [ADDR_WIDTH_Y-1:0] sel_size;
  logic [N_REQ-1:0]        grant_onehot;

  // Search starts at rr_ptr and wraps, so the most recent winner goes last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (GW+1)'(k);
      if (cand >= N_REQ_W) cand = cand - N_REQ_W;
      if (!found && req_valid[cand[GW-1:0]]) begin
        found = 1'b1;
        pick  = cand[GW-1:0];
      end
    end
  end

  assign accept       = (state == IDLE) && !eng_busy && found && !rst;
  assign req_ready    = accept ? (N_REQ'(1) << pick) : '0;
  assign sel_size     = req_size_Y[pick*ADDR_WIDTH_Y +: ADDR_WIDTH_Y];
  assign grant_onehot = N_REQ'(1) << grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_q     <= '0;
      size_q      <= '0;
      base_y_q    <= '0;
      base_z_q    <= '0;
      run_cnt     <= '0;
      cmp_valid_q <= '0;
      cmp_error_q <= '0;
      eng_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      cmp_valid_q <= '0;
      cmp_error_q <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            grant_q  <= pick;
            size_q   <= sel_size;
            base_y_q <= req_base_Y[pick*ADDR_WIDTH_Y +: ADDR_WIDTH_Y];
            base_z_q <= req_base_Z[pick*ADDR_WIDTH_Z +: ADDR_WIDTH_Z];
            rr_ptr   <= (pick == LAST_REQ) ? '0 : pick + 1'b1;
            busy_q   <= 1'b1;
            // An empty job is refused without ever waking the engine.
            if (sel_size == '0) begin
              state       <= COMPLETE;
              cmp_valid_q <= req_ready;
              cmp_error_q <= req_ready;
            end else begin
              state       <= START;
              eng_start_q <= 1'b1;
            end
          end
        end
        START: begin
          run_cnt <= '0;
          state   <= RUN;
        end
        RUN: begin
          run_cnt <= run_cnt + 1'b1;
          if (eng_done) begin
            state       <= COMPLETE;
            cmp_valid_q <= grant_onehot;
          end else if (run_cnt == LAST_RUN) begin
            state       <= COMPLETE;
            cmp_valid_q <= grant_onehot;
            cmp_error_q <= grant_onehot;
          end
        end
        COMPLETE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmp_valid      = cmp_valid_q;
  assign cmp_error      = cmp_error_q;
  assign eng_start      = eng_start_q;
  assign busy           = busy_q;
  assign grant_id       = grant_q;
  assign eng_mem_size_Y = size_q;

  // Writes are only honoured while a job owns the engine, so a timed-out engine cannot scribble.
  assign mem_addr_Y = base_y_q + eng_mem_addr_Y;
  assign mem_addr_Z = base_z_q + eng_mem_addr_Z;
  assign write_Z    = eng_write_Z && ((state == START) || (state == RUN));

endmodule

// File: tb/tb_conv_scheduler.sv
// Bench for conv_scheduler: two instances (long and 16-cycle timeout) share directed stimulus
// and are compared every cycle against a job-level model, plus literal spot checks.
module tb_conv_scheduler;

  localparam int TO0 = 64;
  localparam int TO1 = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [9:0]  req_size_Y;
  logic [9:0]  req_base_Y;
  logic [11:0] req_base_Z;
  logic        eng_busy;
  logic        eng_done;
  logic [4:0]  eng_mem_addr_Y;
  logic        eng_write_Z;
  logic [5:0]  eng_mem_addr_Z;

  logic [1:0] req_ready_o [2];
  logic [1:0] cmp_valid_o [2];
  logic [1:0] cmp_error_o [2];
  logic       busy_o      [2];
  logic [0:0] grant_id_o  [2];
  logic       eng_start_o [2];
  logic [4:0] size_o      [2];
  logic [4:0] mem_addr_Y_o[2];
  logic [5:0] mem_addr_Z_o[2];
  logic       write_Z_o   [2];

  int errors = 0;
  int checks = 0;

  // Job-level model state, one set per instance.
  int m_active[2];
  int m_age[2];
  int m_g[2];
  int m_size[2];
  int m_by[2];
  int m_bz[2];
  int m_zero[2];
  int m_fin[2];
  int m_err[2];
  int m_rr[2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    conv_scheduler #(
      .N_REQ(2), .ADDR_WIDTH_Y(5), .ADDR_WIDTH_Z(6),
      .TIMEOUT_CYCLES(k == 0 ? TO0 : TO1)
    ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready_o[k]),
      .req_size_Y(req_size_Y), .req_base_Y(req_base_Y), .req_base_Z(req_base_Z),
      .cmp_valid(cmp_valid_o[k]), .cmp_error(cmp_error_o[k]),
      .busy(busy_o[k]), .grant_id(grant_id_o[k]),
      .eng_start(eng_start_o[k]), .eng_mem_size_Y(size_o[k]),
      .eng_busy(eng_busy), .eng_done(eng_done),
      .eng_mem_addr_Y(eng_mem_addr_Y), .eng_write_Z(eng_write_Z),
      .eng_mem_addr_Z(eng_mem_addr_Z),
      .mem_addr_Y(mem_addr_Y_o[k]), .mem_addr_Z(mem_addr_Z_o[k]),
      .write_Z(write_Z_o[k])
    );
  end

  task automatic checkOutput(input string name, input int k, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d at %0t: got %0d expected %0d", name, k, $time, act, exp);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int i, input int size, input int by, input int bz);
    req_size_Y[i*5 +: 5] = 5'(size);
    req_base_Y[i*5 +: 5] = 5'(by);
    req_base_Z[i*6 +: 6] = 6'(bz);
  endtask

  // Compare both instances against the model at the negedge, then advance the model one cycle.
  task automatic checkCycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int win;
      int idx;
      int to;
      logic [1:0] e_ready, e_cv, e_ce;
      logic e_busy, e_start, e_wz;
      to = (k == 0) ? TO0 : TO1;
      if (rst) begin
        m_active[k] = 0; m_age[k] = 0; m_g[k] = 0; m_size[k] = 0;
        m_by[k] = 0; m_bz[k] = 0; m_zero[k] = 0; m_fin[k] = -1; m_err[k] = 0; m_rr[k] = 0;
      end
      win = -1;
      if (!rst && m_active[k] == 0 && !eng_busy)
        for (int i = 0; i < 2; i++) begin
          idx = (m_rr[k] + i) % 2;
          if (win < 0 && req_valid[idx]) win = idx;
        end
      e_ready = (win >= 0) ? 2'(1 << win) : 2'b00;
      e_cv = 2'b00; e_ce = 2'b00; e_busy = 1'b0; e_start = 1'b0; e_wz = 1'b0;
      if (m_active[k] != 0) begin
        e_busy = 1'b1;
        if (m_zero[k] != 0) begin
          e_cv = 2'(1 << m_g[k]);
          e_ce = e_cv;
        end else if (m_age[k] == 1) begin
          e_start = 1'b1;
          e_wz    = eng_write_Z;
        end else if (m_age[k] == m_fin[k]) begin
          e_cv = 2'(1 << m_g[k]);
          e_ce = (m_err[k] != 0) ? e_cv : 2'b00;
        end else begin
          e_wz = eng_write_Z;
        end
      end
      checkOutput("req_ready", k, 32'(req_ready_o[k]), 32'(e_ready));
      checkOutput("cmp_valid", k, 32'(cmp_valid_o[k]), 32'(e_cv));
      checkOutput("cmp_error", k, 32'(cmp_error_o[k]), 32'(e_ce));
      checkOutput("busy", k, 32'(busy_o[k]), 32'(e_busy));
      checkOutput("eng_start", k, 32'(eng_start_o[k]), 32'(e_start));
      checkOutput("write_Z", k, 32'(write_Z_o[k]), 32'(e_wz));
      checkOutput("grant_id", k, 32'(grant_id_o[k]), 32'(m_g[k]));
      checkOutput("mem_size_Y", k, 32'(size_o[k]), 32'(m_size[k]));
      checkOutput("mem_addr_Y", k, 32'(mem_addr_Y_o[k]), 32'((m_by[k] + eng_mem_addr_Y) % 32));
      checkOutput("mem_addr_Z", k, 32'(mem_addr_Z_o[k]), 32'((m_bz[k] + eng_mem_addr_Z) % 64));
      if (!rst) begin
        if (m_active[k] != 0) begin
          if (m_zero[k] != 0 || m_age[k] == m_fin[k]) m_active[k] = 0;
          else if (m_age[k] >= 2 && m_fin[k] < 0) begin
            if (eng_done) begin
              m_fin[k] = m_age[k] + 1; m_err[k] = 0;
            end else if (m_age[k] - 2 == to - 1) begin
              m_fin[k] = m_age[k] + 1; m_err[k] = 1;
            end
          end
          m_age[k]++;
        end else if (win >= 0) begin
          m_active[k] = 1; m_age[k] = 1; m_g[k] = win; m_fin[k] = -1; m_err[k] = 0;
          m_size[k] = int'(req_size_Y[win*5 +: 5]);
          m_by[k]   = int'(req_base_Y[win*5 +: 5]);
          m_bz[k]   = int'(req_base_Z[win*6 +: 6]);
          m_zero[k] = (m_size[k] == 0) ? 1 : 0;
          m_rr[k]   = (win + 1) % 2;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      checkCycle();
      applyStimulus();
    end
  endtask

  initial begin
    int n;
    int last;
    int gsel;
    logic saw_start;
    rst = 1'b1; req_valid = '0; req_size_Y = '0; req_base_Y = '0; req_base_Z = '0;
    eng_busy = 1'b0; eng_done = 1'b0; eng_write_Z = 1'b0;
    eng_mem_addr_Y = '0; eng_mem_addr_Z = '0;
    $display("[TB] start");
    idle(2);
    rst = 1'b0;
    checkCycle();
    for (int k = 0; k < 2; k++) begin
      checkOutput("rst_busy", k, 32'(busy_o[k]), 0);
      checkOutput("rst_grant", k, 32'(grant_id_o[k]), 0);
      checkOutput("rst_size", k, 32'(size_o[k]), 0);
    end
    applyStimulus();

    // Single job, done 20 cycles after start; dut1 times out first.
    setReq(0, 10, 4, 8);
    req_valid = 2'b01;
    checkCycle();
    checkOutput("single_accept", 0, 32'(req_ready_o[0]), 1);
    applyStimulus();
    req_valid = 2'b00;
    checkCycle();
    checkOutput("single_start", 0, 32'(eng_start_o[0]), 1);
    checkOutput("single_size", 0, 32'(size_o[0]), 10);
    applyStimulus();
    eng_busy = 1'b1; eng_write_Z = 1'b1;
    for (int j = 0; j < 19; j++) begin
      eng_mem_addr_Y = 5'(j % 10);
      eng_mem_addr_Z = 6'(j);
      checkCycle();
      checkOutput("single_addr_Y", 0, 32'(mem_addr_Y_o[0]), 32'(4 + j % 10));
      checkOutput("single_addr_Z", 0, 32'(mem_addr_Z_o[0]), 32'(8 + j));
      checkOutput("single_write_Z", 0, 32'(write_Z_o[0]), 1);
      if (j == 16) begin
        checkOutput("single_to_valid", 1, 32'(cmp_valid_o[1]), 1);
        checkOutput("single_to_error", 1, 32'(cmp_error_o[1]), 1);
      end
      applyStimulus();
    end
    eng_done = 1'b1; eng_write_Z = 1'b0; eng_mem_addr_Y = '0; eng_mem_addr_Z = '0;
    idle(1);
    eng_done = 1'b0; eng_busy = 1'b0;
    checkCycle();
    checkOutput("single_cmp_valid", 0, 32'(cmp_valid_o[0]), 1);
    checkOutput("single_cmp_error", 0, 32'(cmp_error_o[0]), 0);
    applyStimulus();
    idle(2);

    // Window wrap-around on requester 1.
    setReq(1, 7, 28, 60);
    eng_mem_addr_Y = 5'd6; eng_mem_addr_Z = 6'd10;
    req_valid = 2'b10;
    checkCycle();
    checkOutput("wrap_accept", 0, 32'(req_ready_o[0]), 2);
    applyStimulus();
    req_valid = 2'b00;
    checkCycle();
    checkOutput("wrap_addr_Y", 0, 32'(mem_addr_Y_o[0]), 2);
    checkOutput("wrap_addr_Z", 0, 32'(mem_addr_Z_o[0]), 6);
    applyStimulus();
    eng_done = 1'b1;
    idle(1);
    eng_done = 1'b0;
    checkCycle();
    checkOutput("wrap_cmp_valid", 0, 32'(cmp_valid_o[0]), 2);
    applyStimulus();
    eng_mem_addr_Y = '0; eng_mem_addr_Z = '0;
    idle(1);

    // Zero-size job is refused at T+1 without starting the engine.
    setReq(1, 0, 3, 5);
    req_valid = 2'b10;
    checkCycle();
    checkOutput("zero_accept", 0, 32'(req_ready_o[0]), 2);
    applyStimulus();
    req_valid = 2'b00;
    checkCycle();
    checkOutput("zero_cmp_valid", 0, 32'(cmp_valid_o[0]), 2);
    checkOutput("zero_cmp_error", 0, 32'(cmp_error_o[0]), 2);
    checkOutput("zero_no_start", 0, 32'(eng_start_o[0]), 0);
    applyStimulus();
    checkCycle();
    checkOutput("zero_idle", 0, 32'(busy_o[0]), 0);
    applyStimulus();

    // Fairness: both requesters held, engine finishes as soon as it is started.
    setReq(0, 4, 1, 2);
    setReq(1, 6, 9, 20);
    req_valid = 2'b11;
    n = 0; last = -100; saw_start = 1'b0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      eng_done = saw_start;
      checkCycle();
      if (req_ready_o[0] != 2'b00) begin
        gsel = req_ready_o[0][1] ? 1 : 0;
        checkOutput("fair_grant", 0, 32'(gsel), 32'(n % 2));
        if (n > 0) checkOutput("fair_spacing", 0, 32'(c - last), 4);
        last = c;
        n++;
      end
      saw_start = eng_start_o[0];
      applyStimulus();
    end
    req_valid = 2'b00;
    checkOutput("fair_count", 0, 32'(n), 4);
    repeat (6) begin
      eng_done = saw_start;
      checkCycle();
      saw_start = eng_start_o[0];
      applyStimulus();
    end
    eng_done = 1'b0;

    // Timeout: engine stays busy and never finishes; req1 waits behind it.
    setReq(0, 5, 0, 0);
    setReq(1, 4, 0, 0);
    req_valid = 2'b01;
    checkCycle();
    checkOutput("to_accept", 1, 32'(req_ready_o[1]), 1);
    applyStimulus();
    req_valid = 2'b10;
    idle(1);
    eng_busy = 1'b1;
    for (int j = 0; j < 26; j++) begin
      eng_write_Z = j[0];
      checkCycle();
      if (j == 15) checkOutput("to_not_yet", 1, 32'(cmp_valid_o[1]), 0);
      if (j == 16) begin
        checkOutput("to_cmp_valid", 1, 32'(cmp_valid_o[1]), 1);
        checkOutput("to_cmp_error", 1, 32'(cmp_error_o[1]), 1);
      end
      if (j > 16) begin
        checkOutput("to_no_grant", 1, 32'(req_ready_o[1]), 0);
        checkOutput("to_write_blocked", 1, 32'(write_Z_o[1]), 0);
      end
      applyStimulus();
    end
    eng_busy = 1'b0;
    checkCycle();
    checkOutput("to_grant_after_busy", 1, 32'(req_ready_o[1]), 2);
    applyStimulus();
    rst = 1'b1; req_valid = 2'b00; eng_write_Z = 1'b0;
    idle(1);
    rst = 1'b0;
    idle(1);

    // Reset during RUN discards the job; pending req1 wins afterwards.
    setReq(0, 8, 3, 3);
    req_valid = 2'b01;
    checkCycle();
    checkOutput("rr_accept0", 0, 32'(req_ready_o[0]), 1);
    applyStimulus();
    req_valid = 2'b10;
    idle(1);
    eng_busy = 1'b1; eng_write_Z = 1'b1;
    idle(5);
    rst = 1'b1; eng_busy = 1'b0;
    checkCycle();
    for (int k = 0; k < 2; k++) begin
      checkOutput("rstrun_busy", k, 32'(busy_o[k]), 0);
      checkOutput("rstrun_ready", k, 32'(req_ready_o[k]), 0);
      checkOutput("rstrun_cmp", k, 32'(cmp_valid_o[k]), 0);
      checkOutput("rstrun_write_Z", k, 32'(write_Z_o[k]), 0);
      checkOutput("rstrun_start", k, 32'(eng_start_o[k]), 0);
      checkOutput("rstrun_size", k, 32'(size_o[k]), 0);
      checkOutput("rstrun_addr_Y", k, 32'(mem_addr_Y_o[k]), 0);
    end
    applyStimulus();
    rst = 1'b0;
    checkCycle();
    checkOutput("rstrun_req1_first", 0, 32'(req_ready_o[0]), 2);
    applyStimulus();
    req_valid = 2'b00; eng_write_Z = 1'b0;
    checkCycle();
    checkOutput("rstrun_grant_id", 0, 32'(grant_id_o[0]), 1);
    checkOutput("rstrun_start1", 0, 32'(eng_start_o[0]), 1);
    applyStimulus();
    eng_done = 1'b1;
    idle(1);
    eng_done = 1'b0;
    checkCycle();
    checkOutput("rstrun_cmp1", 0, 32'(cmp_valid_o[0]), 2);
    applyStimulus();
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
